// File: rtl/gps_sample_player_if.sv
// Sample-memory read bus and sample stream of the GPS sample player.
// The master side is the player; the slave side is memory plus correlator.
interface gps_sample_player_if #(
    parameter int ADDR_W = 22
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_data;
    logic              smp_data;
    logic              smp_valid;
    logic              smp_ready;

    modport master (
        output mem_addr,
        input  mem_data,
        output smp_data,
        output smp_valid,
        input  smp_ready
    );

    modport slave (
        input  mem_addr,
        output mem_data,
        input  smp_data,
        input  smp_valid,
        output smp_ready
    );
endinterface

// File: rtl/gps_sample_player.sv
// GPS sample player: paces reads over a (base, len) window of the 1-bit sample
// memory and streams the returned bits through a 2-entry buffer.
//
//   state | meaning
//   IDLE  | waiting for an accepted start
//   RUN   | issuing reads, pace-limited and buffer-credit-limited
//   DRAIN | one-shot window fully issued; emptying the buffer
module gps_sample_player #(
    parameter int ADDR_W    = 22,
    parameter int MEM_DEPTH = 4000000,
    parameter int DIV_W     = 8,
    parameter int EPOCH_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [ADDR_W-1:0]  cfg_base_i,
    input  logic [ADDR_W-1:0]  cfg_len_i,
    input  logic               cfg_loop_i,
    input  logic [DIV_W-1:0]   cfg_div_i,
    gps_sample_player_if.master bus,
    output logic               busy_o,
    output logic               done_o,
    output logic               cfg_err_o,
    output logic [EPOCH_W-1:0] epoch_cnt_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

    state_t             state_q;
    logic [ADDR_W-1:0]  base_q, len_q, offset_q, mem_addr_q;
    logic               loop_q;
    logic [DIV_W-1:0]   div_q, pace_q;
    logic               inflight_q;
    logic               fifo0_q, fifo1_q;
    logic [1:0]         cnt_q, cnt_d;
    logic               err_q;
    logic [EPOCH_W-1:0] epoch_q;

    logic [ADDR_W:0]    cfg_end;
    logic               cfg_ok, pop, push, issue, last;
    logic [2:0]         occ;
    logic               wr_slot;

    // Handshake, credit and issue decisions for the current cycle.
    always_comb begin
        cfg_end = {1'b0, cfg_base_i} + {1'b0, cfg_len_i};
        cfg_ok  = (cfg_len_i != '0) && (cfg_end <= DEPTH_L);
        pop     = (cnt_q != 2'd0) && bus.smp_ready;
        push    = inflight_q;
        // A sample popped this cycle frees its slot before the issued read
        // returns, so it counts as credit; this keeps div=0 at one per cycle.
        occ     = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
        issue   = (state_q == RUN) && (pace_q == '0) && (occ < 3'd2);
        last    = (offset_q == len_q - ADDR_W'(1));
        cnt_d   = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 2'd1;
        else if (pop && !push) cnt_d = cnt_q - 2'd1;
        wr_slot = cnt_q[0] ^ pop;
        done_o  = rst_ni && !stop_i && (state_q == DRAIN) && pop &&
                  (cnt_q == 2'd1) && !inflight_q;
    end

    // Control FSM: configuration capture, pacing, offset/wrap and read issue.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            div_q      <= '0;
            offset_q   <= '0;
            pace_q     <= '0;
            inflight_q <= 1'b0;
            mem_addr_q <= '0;
            err_q      <= 1'b0;
            epoch_q    <= '0;
        end else if (stop_i) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (pace_q != '0) pace_q <= pace_q - DIV_W'(1);
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (cfg_ok) begin
                            base_q   <= cfg_base_i;
                            len_q    <= cfg_len_i;
                            loop_q   <= cfg_loop_i;
                            div_q    <= cfg_div_i;
                            offset_q <= '0;
                            pace_q   <= '0;
                            err_q    <= 1'b0;
                            epoch_q  <= '0;
                            state_q  <= RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        mem_addr_q <= base_q + offset_q;
                        pace_q     <= div_q;
                        if (!last) begin
                            offset_q <= offset_q + ADDR_W'(1);
                        end else if (loop_q) begin
                            offset_q <= '0;
                            epoch_q  <= epoch_q + EPOCH_W'(1);
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_d == 2'd0) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Two-entry output buffer; fifo0_q is always the head.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= 2'd0;
            fifo0_q <= 1'b0;
            fifo1_q <= 1'b0;
        end else if (stop_i) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            if (pop) fifo0_q <= fifo1_q;
            if (push) begin
                if (!wr_slot) fifo0_q <= bus.mem_data;
                else          fifo1_q <= bus.mem_data;
            end
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.smp_data  = fifo0_q;
    assign bus.smp_valid = (cnt_q != 2'd0);
    assign busy_o        = (state_q != IDLE);
    assign cfg_err_o     = err_q;
    assign epoch_cnt_o   = epoch_q;

endmodule

// File: tb/tb_gps_sample_player.sv
// Self-checking bench for gps_sample_player: directed scenarios plus
// randomized one-shot windows, checked against a window/stream model.
module tb_gps_sample_player;

    localparam int ADDR_W  = 22;
    localparam int DIV_W   = 8;
    localparam int EPOCH_W = 16;
    localparam int NMAX    = 256;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start, stop;
    logic [ADDR_W-1:0]  cfg_base, cfg_len;
    logic               cfg_loop;
    logic [DIV_W-1:0]   cfg_div;
    logic               busy, done, cfg_err;
    logic [EPOCH_W-1:0] epoch_cnt;
    logic [63:0]        tbl;

    gps_sample_player_if #(.ADDR_W(ADDR_W)) pif();

    gps_sample_player #(
        .ADDR_W(ADDR_W), .MEM_DEPTH(4000000), .DIV_W(DIV_W), .EPOCH_W(EPOCH_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
        .cfg_base_i(cfg_base), .cfg_len_i(cfg_len), .cfg_loop_i(cfg_loop),
        .cfg_div_i(cfg_div), .bus(pif), .busy_o(busy), .done_o(done),
        .cfg_err_o(cfg_err), .epoch_cnt_o(epoch_cnt)
    );

    always #5 clk = ~clk;

    // Sample memory contents: a scrambled function of the address.
    assign pif.mem_data = tbl[pif.mem_addr[5:0]] ^ pif.mem_addr[9] ^ pif.mem_addr[13];

    function automatic logic memfn(input int unsigned a);
        logic [31:0] av;
        av = a;
        return tbl[av[5:0]] ^ av[9] ^ av[13];
    endfunction

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scenario controls and per-cycle observations.
    int unsigned p_base, p_len, p_div;
    logic        p_loop;
    int          rdy_pct, rdy_lo, rdy_hi, stop_cyc, rst_cyc;
    logic        do_start;

    int unsigned addr_at[NMAX];
    logic        valid_at[NMAX], busy_at[NMAX], err_at[NMAX];
    int unsigned epoch_at[NMAX];
    logic        acc_q[$];
    int          acc_cyc[$];
    int          n_done, done_cyc;

    // Cycle c: inputs are driven at the negedge of cycle c and take effect
    // at the posedge that ends it; outputs are recorded 1 ns later.
    task automatic play(input int ncyc);
        logic rdy;
        acc_q.delete();
        acc_cyc.delete();
        n_done   = 0;
        done_cyc = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            start = do_start && (c == 0);
            stop  = (c == stop_cyc);
            rst_n = !(c == rst_cyc);
            if (c == 0) begin
                cfg_base = ADDR_W'(p_base);
                cfg_len  = ADDR_W'(p_len);
                cfg_loop = p_loop;
                cfg_div  = DIV_W'(p_div);
            end else begin
                cfg_base = ADDR_W'($urandom);
                cfg_len  = ADDR_W'($urandom);
                cfg_loop = 1'($urandom);
                cfg_div  = DIV_W'($urandom);
            end
            if (c >= rdy_lo && c <= rdy_hi) rdy = 1'b0;
            else rdy = ($urandom_range(99) < rdy_pct);
            pif.smp_ready = rdy;
            #1;
            addr_at[c]  = pif.mem_addr;
            valid_at[c] = pif.smp_valid;
            busy_at[c]  = busy;
            err_at[c]   = cfg_err;
            epoch_at[c] = epoch_cnt;
            if (pif.smp_valid && rdy) begin
                acc_q.push_back(pif.smp_data);
                acc_cyc.push_back(c);
            end
            if (done) begin
                n_done++;
                done_cyc = c;
            end
        end
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        rst_n = 1'b1;
        pif.smp_ready = 1'b1;
    endtask

    task automatic setup(input int unsigned b, input int unsigned l, input logic lp,
                         input int unsigned d, input int pct);
        p_base = b; p_len = l; p_loop = lp; p_div = d; rdy_pct = pct;
        rdy_lo = -1; rdy_hi = -1; stop_cyc = -1; rst_cyc = -1; do_start = 1'b1;
    endtask

    // Expected stream: sample k comes from address base + (k mod len).
    task automatic chk_stream(input string tag, input int exp_n);
        chk({tag, "_count"}, acc_q.size(), exp_n);
        for (int k = 0; k < acc_q.size() && k < exp_n; k++)
            chk($sformatf("%s_smp%0d", tag, k), acc_q[k], memfn(p_base + (k % p_len)));
    endtask

    int viol;

    initial begin
        tbl = {$urandom, $urandom};
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        cfg_base = '0; cfg_len = '0; cfg_loop = 1'b0; cfg_div = '0;
        pif.smp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_addr",  pif.mem_addr, 0);
        chk("rst_valid", pif.smp_valid, 0);
        chk("rst_data",  pif.smp_data, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_done",  done, 0);
        chk("rst_err",   cfg_err, 0);
        chk("rst_epoch", epoch_cnt, 0);
        rst_n = 1'b1;

        // One-shot, back-to-back.
        setup(100, 4, 1'b0, 0, 100);
        play(12);
        for (int k = 0; k < 4; k++) chk($sformatf("os_addr%0d", k), addr_at[2+k], 100 + k);
        chk("os_valid2", valid_at[2], 0);
        chk("os_valid3", valid_at[3], 1);
        chk_stream("os", 4);
        for (int k = 0; k < acc_cyc.size(); k++) chk($sformatf("os_acc_cyc%0d", k), acc_cyc[k], 3 + k);
        chk("os_ndone", n_done, 1);
        chk("os_done_cyc", done_cyc, 6);
        chk("os_busy6", busy_at[6], 1);
        chk("os_busy7", busy_at[7], 0);

        // Pacing.
        setup(0, 3, 1'b0, 2, 100);
        play(16);
        begin
            int nv = 0;
            for (int c = 0; c < 16; c++) nv += valid_at[c];
            chk("pace_valid_cycles", nv, 3);
        end
        chk_stream("pace", 3);
        for (int k = 0; k < acc_cyc.size(); k++) chk($sformatf("pace_acc_cyc%0d", k), acc_cyc[k], 3 + 3*k);
        chk("pace_ndone", n_done, 1);

        // Backpressure burst mid-stream.
        setup(200, 8, 1'b0, 0, 100);
        rdy_lo = 5; rdy_hi = 9;
        play(30);
        chk_stream("bp", 8);
        chk("bp_ndone", n_done, 1);
        chk("bp_done_last", done_cyc, acc_cyc[acc_cyc.size()-1]);

        // Loop at the top of memory, then stop.
        setup(3999996, 4, 1'b1, 0, 100);
        stop_cyc = 20;
        play(24);
        chk("loop_err", err_at[1], 0);
        for (int k = 0; k < 5; k++) chk($sformatf("loop_addr%0d", k), addr_at[2+k], 3999996 + (k % 4));
        chk("loop_epoch4", epoch_at[4], 0);
        chk("loop_epoch5", epoch_at[5], 1);
        chk("loop_epoch13", epoch_at[13], 3);
        chk_stream("loop", 18);
        chk("loop_ndone", n_done, 0);
        chk("loop_busy_after_stop", busy_at[21], 0);
        chk("loop_valid_after_stop", valid_at[21], 0);

        // Configuration errors.
        setup(3999998, 4, 1'b0, 0, 100);
        play(3);
        chk("bad_end_err", err_at[1], 1);
        chk("bad_end_busy", busy_at[1], 0);
        setup(10, 2, 1'b0, 0, 100);
        play(10);
        chk("good_err", err_at[1], 0);
        chk("good_busy", busy_at[1], 1);
        setup(0, 0, 1'b0, 0, 100);
        play(3);
        chk("len0_err", err_at[1], 1);
        chk("len0_busy", busy_at[1], 0);

        // Stop with the buffer full.
        setup(50, 10, 1'b0, 0, 0);
        stop_cyc = 6;
        play(10);
        chk("stop_valid6", valid_at[6], 1);
        chk("stop_valid7", valid_at[7], 0);
        chk("stop_busy7", busy_at[7], 0);
        chk("stop_ndone", n_done, 0);
        chk("stop_err", err_at[7], 0);

        // Stop and start together: start ignored.
        setup(10, 4, 1'b0, 0, 100);
        stop_cyc = 0;
        play(3);
        chk("stopstart_busy", busy_at[1], 0);

        // Reset while running a loop.
        setup(0, 2, 1'b1, 0, 100);
        rst_cyc = 9;
        play(11);
        chk("rrun_epoch_pre", epoch_at[9] > 0, 1);
        chk("rrun_addr",  addr_at[10], 0);
        chk("rrun_valid", valid_at[10], 0);
        chk("rrun_busy",  busy_at[10], 0);
        chk("rrun_epoch", epoch_at[10], 0);
        chk("rrun_err",   err_at[10], 0);

        // Randomized one-shot windows.
        for (int i = 0; i < 8; i++) begin
            setup($urandom_range(3999000), $urandom_range(1, 20), 1'b0,
                  $urandom_range(3), (i < 3) ? 100 : 60);
            play(200);
            chk_stream($sformatf("rnd%0d", i), p_len);
            chk($sformatf("rnd%0d_ndone", i), n_done, 1);
            if (acc_cyc.size() > 0)
                chk($sformatf("rnd%0d_done_last", i), done_cyc, acc_cyc[acc_cyc.size()-1]);
            viol = 0;
            for (int c = 2; c < 200; c++)
                if (addr_at[c] < p_base || addr_at[c] > p_base + p_len - 1) viol++;
            chk($sformatf("rnd%0d_addr_range", i), viol, 0);
            if (rdy_pct == 100)
                for (int k = 0; k < acc_cyc.size(); k++)
                    chk($sformatf("rnd%0d_acc_cyc%0d", i, k), acc_cyc[k], 3 + k*(p_div+1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
